// File: rtl/mem_responder_if.sv
// Request/response bundle between the datapath's MAR/MDR and the memory responder.
// The master drives address, write data and strobes; the slave returns data and status.
interface mem_responder_if #(
   parameter int DATA_W = 16
);
   logic [15:0]       mem_addr;
   logic [DATA_W-1:0] mem_data_in;
   logic              mem_rd;
   logic              mem_wr;
   logic [DATA_W-1:0] mem_data_out;
   logic              mem_ready;
   logic              mem_busy;
   logic              mem_err;

   modport master (
      output mem_addr, mem_data_in, mem_rd, mem_wr,
      input  mem_data_out, mem_ready, mem_busy, mem_err
   );

   modport slave (
      input  mem_addr, mem_data_in, mem_rd, mem_wr,
      output mem_data_out, mem_ready, mem_busy, mem_err
   );
endinterface

// File: rtl/mem_responder.sv
// Word-addressed RAM responder with programmable wait states and a one-cycle ready/err pulse.
// Define MEM_PROTECT_EN to reject writes to words 0..PROT_LIMIT-1.
module mem_responder #(
   parameter int DATA_W      = 16,
   parameter int ADDR_W      = 8,
   parameter int WAIT_CYCLES = 2,
   parameter int PROT_LIMIT  = 16
) (
   input logic             clk,
   input logic             reset,
   mem_responder_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

`ifdef MEM_PROTECT_EN
   localparam logic PROT_ON = 1'b1;
`else
   localparam logic PROT_ON = 1'b0;
`endif

   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [15:0]       addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              rd_q, rd_d;
   logic              wr_q, wr_d;
   logic              err_q, err_d;

   logic [DATA_W-1:0] ram [2**ADDR_W];

   logic [ADDR_W-1:0] idx;
   logic              outOfRange;
   logic              conflict;
   logic              protHit;
   logic              accessErr;
   logic              accessNow;
   logic              ramWe;

   assign idx        = addr_q[ADDR_W-1:0];
   assign outOfRange = (addr_q >> ADDR_W) != 16'd0;
   assign conflict   = rd_q & wr_q;
   assign protHit    = PROT_ON & wr_q & (32'(addr_q) < 32'(PROT_LIMIT));
   assign accessErr  = conflict | outOfRange | protHit;
   assign accessNow  = (state_q == WAIT) && (cnt_q == 4'd0);
   assign ramWe      = accessNow & wr_q & ~accessErr;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         addr_q  <= 16'd0;
         wdata_q <= '0;
         rdata_q <= '0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         err_q   <= err_d;
      end
   end

   // Requests are captured only in IDLE; anything arriving while busy is dropped.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      rd_d    = rd_q;
      wr_d    = wr_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (bus.mem_rd || bus.mem_wr) begin
               addr_d  = bus.mem_addr;
               wdata_d = bus.mem_data_in;
               rd_d    = bus.mem_rd;
               wr_d    = bus.mem_wr;
               cnt_d   = 4'(WAIT_CYCLES);
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d = DONE;
               err_d   = accessErr;
               if (rd_q && !wr_q) begin
                  rdata_d = outOfRange ? '0 : ram[idx];
               end
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         DONE: begin
            state_d = IDLE;
            err_d   = 1'b0;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.mem_ready    = (state_q == DONE);
      bus.mem_err      = (state_q == DONE) & err_q;
      bus.mem_busy     = (state_q != IDLE);
      bus.mem_data_out = rdata_q;
   end

   // RAM contents deliberately survive reset.
   always_ff @(posedge clk) begin
      if (ramWe) begin
         ram[idx] <= wdata_q;
      end
   end

endmodule

// File: tb/tb_mem_responder.sv
// Directed, table-driven bench for mem_responder (WAIT_CYCLES=2 main instance, WAIT_CYCLES=0 boundary instance).
// Honours MEM_PROTECT_EN when the design is built with it.
module tb_mem_responder;

`ifdef MEM_PROTECT_EN
   localparam bit PROT = 1'b1;
`else
   localparam bit PROT = 1'b0;
`endif
   localparam logic [15:0] A0 = PROT ? 16'h0040 : 16'h0000;

   typedef struct {
      string       name;
      logic        rd;
      logic        wr;
      logic [15:0] addr;
      logic [15:0] wdata;
      logic [15:0] expData;
      logic        expErr;
      bit          notEq;
   } vec_t;

   logic clk;
   logic reset;
   int   checks;
   int   errors;
   vec_t vecs[$];

   mem_responder_if #(.DATA_W(16)) bus ();
   mem_responder_if #(.DATA_W(16)) bus0 ();

   mem_responder #(.DATA_W(16), .ADDR_W(8), .WAIT_CYCLES(2), .PROT_LIMIT(16)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   mem_responder #(.DATA_W(16), .ADDR_W(8), .WAIT_CYCLES(0), .PROT_LIMIT(16)) dut0 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic checkDiffers(input string name, input logic [31:0] actual, input logic [31:0] forbidden);
      checks++;
      if (actual === forbidden) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected anything but 0x%0h", name, actual, forbidden);
      end
   endtask

   task automatic driveBus(input bit sel, input logic rd, input logic wr, input logic [15:0] addr, input logic [15:0] wdata);
      if (sel) begin
         bus0.mem_rd = rd; bus0.mem_wr = wr; bus0.mem_addr = addr; bus0.mem_data_in = wdata;
      end else begin
         bus.mem_rd = rd; bus.mem_wr = wr; bus.mem_addr = addr; bus.mem_data_in = wdata;
      end
   endtask

   function automatic logic readyOf(input bit sel);
      return sel ? bus0.mem_ready : bus.mem_ready;
   endfunction

   function automatic logic busyOf(input bit sel);
      return sel ? bus0.mem_busy : bus.mem_busy;
   endfunction

   function automatic logic errOf(input bit sel);
      return sel ? bus0.mem_err : bus.mem_err;
   endfunction

   function automatic logic [15:0] dataOf(input bit sel);
      return sel ? bus0.mem_data_out : bus.mem_data_out;
   endfunction

   // Called at a falling edge; lat counts falling edges after the sampling edge until ready (-1 on timeout).
   task automatic applyStimulus(input bit sel, input logic rd, input logic wr, input logic [15:0] addr,
                                input logic [15:0] wdata, output int lat, output logic busyFirst);
      driveBus(sel, rd, wr, addr, wdata);
      @(negedge clk);
      driveBus(sel, 1'b0, 1'b0, 16'h0000, 16'h0000);
      busyFirst = busyOf(sel);
      lat = 1;
      while (!readyOf(sel) && lat < 30) begin
         @(negedge clk);
         lat++;
      end
      if (!readyOf(sel)) lat = -1;
   endtask

   task automatic runVector(input bit sel, input vec_t v, input int expLat);
      int   lat;
      logic busyFirst;
      applyStimulus(sel, v.rd, v.wr, v.addr, v.wdata, lat, busyFirst);
      checkOutput({v.name, "_busy"}, {31'd0, busyFirst}, 32'd1);
      checkOutput({v.name, "_latency"}, lat, expLat);
      if (v.notEq) checkDiffers({v.name, "_data"}, {16'd0, dataOf(sel)}, {16'd0, v.expData});
      else         checkOutput({v.name, "_data"}, {16'd0, dataOf(sel)}, {16'd0, v.expData});
      checkOutput({v.name, "_err"}, {31'd0, errOf(sel)}, {31'd0, v.expErr});
      @(negedge clk);
      checkOutput({v.name, "_readyPulse"}, {31'd0, readyOf(sel)}, 32'd0);
      checkOutput({v.name, "_idle"}, {31'd0, busyOf(sel)}, 32'd0);
   endtask

   task automatic addVec(input string name, input logic rd, input logic wr, input logic [15:0] addr,
                         input logic [15:0] wdata, input logic [15:0] expData, input logic expErr, input bit notEq);
      vec_t v;
      v.name = name; v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata;
      v.expData = expData; v.expErr = expErr; v.notEq = notEq;
      vecs.push_back(v);
   endtask

   initial begin
      int   pulses;
      int   lat;
      logic busyFirst;
      checks = 0;
      errors = 0;

      addVec("wr25",      1'b0, 1'b1, 16'h0025, 16'h1234, 16'h0000, 1'b0, 1'b0);
      addVec("rd25",      1'b1, 1'b0, 16'h0025, 16'h0000, 16'h1234, 1'b0, 1'b0);
      addVec("wrA0",      1'b0, 1'b1, A0,       16'h0BAD, 16'h1234, 1'b0, 1'b0);
      addVec("rdOor",     1'b1, 1'b0, 16'h0100, 16'h0000, 16'h0000, 1'b1, 1'b0);
      addVec("rdA0",      1'b1, 1'b0, A0,       16'h0000, 16'h0BAD, 1'b0, 1'b0);
      addVec("wr10",      1'b0, 1'b1, 16'h0010, 16'hBEEF, 16'h0BAD, 1'b0, 1'b0);
      addVec("rd10",      1'b1, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0, 1'b0);
      addVec("rdwr10",    1'b1, 1'b1, 16'h0010, 16'h1111, 16'hBEEF, 1'b1, 1'b0);
      addVec("rdA0b",     1'b1, 1'b0, A0,       16'h0000, 16'h0BAD, 1'b0, 1'b0);
      addVec("rd10Keep",  1'b1, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0, 1'b0);
      addVec("wr30",      1'b0, 1'b1, 16'h0030, 16'h7777, 16'hBEEF, 1'b0, 1'b0);
      addVec("wrOor",     1'b0, 1'b1, 16'h1025, 16'hDEAD, 16'hBEEF, 1'b1, 1'b0);
      addVec("rd25Alias", 1'b1, 1'b0, 16'h0025, 16'h0000, 16'h1234, 1'b0, 1'b0);
      addVec("wr0F",      1'b0, 1'b1, 16'h000F, 16'h5555, 16'h1234, PROT, 1'b0);
      addVec("rd0F",      1'b1, 1'b0, 16'h000F, 16'h0000, 16'h5555, 1'b0, PROT);
      addVec("rd25b",     1'b1, 1'b0, 16'h0025, 16'h0000, 16'h1234, 1'b0, 1'b0);
      addVec("wr10b",     1'b0, 1'b1, 16'h0010, 16'h2222, 16'h1234, 1'b0, 1'b0);
      addVec("rd10b",     1'b1, 1'b0, 16'h0010, 16'h0000, 16'h2222, 1'b0, 1'b0);

      reset = 1'b1;
      driveBus(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
      driveBus(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
      repeat (2) @(negedge clk);
      checkOutput("rst_ready", {31'd0, bus.mem_ready}, 32'd0);
      checkOutput("rst_busy",  {31'd0, bus.mem_busy},  32'd0);
      checkOutput("rst_err",   {31'd0, bus.mem_err},   32'd0);
      checkOutput("rst_data",  {16'd0, bus.mem_data_out}, 32'd0);
      reset = 1'b0;
      @(negedge clk);

      $display("[TB] running %0d table vectors", vecs.size());
      for (int i = 0; i < vecs.size(); i++) begin
         runVector(1'b0, vecs[i], 4);
      end

      // Reset while the write is still counting wait states.
      driveBus(1'b0, 1'b0, 1'b1, 16'h0030, 16'hAAAA);
      @(negedge clk);
      driveBus(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
      @(negedge clk);
      reset = 1'b1;
      #1;
      checkOutput("abort_ready", {31'd0, bus.mem_ready}, 32'd0);
      checkOutput("abort_busy",  {31'd0, bus.mem_busy},  32'd0);
      checkOutput("abort_err",   {31'd0, bus.mem_err},   32'd0);
      checkOutput("abort_data",  {16'd0, bus.mem_data_out}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      pulses = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (bus.mem_ready) pulses++;
      end
      checkOutput("abort_noReady", pulses, 0);
      runVector(1'b0, '{name:"rd30Prior", rd:1'b1, wr:1'b0, addr:16'h0030, wdata:16'h0000,
                         expData:16'h7777, expErr:1'b0, notEq:1'b0}, 4);

      // A write issued while busy must be dropped, not queued.
      driveBus(1'b0, 1'b1, 1'b0, 16'h0025, 16'h0000);
      @(negedge clk);
      driveBus(1'b0, 1'b0, 1'b1, 16'h0025, 16'h9999);
      @(negedge clk);
      driveBus(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
      pulses = 0;
      for (int c = 0; c < 12; c++) begin
         if (bus.mem_ready) pulses++;
         @(negedge clk);
      end
      checkOutput("ignored_pulses", pulses, 1);
      checkOutput("ignored_data", {16'd0, bus.mem_data_out}, 32'h1234);
      runVector(1'b0, '{name:"rd25NoOverwrite", rd:1'b1, wr:1'b0, addr:16'h0025, wdata:16'h0000,
                         expData:16'h1234, expErr:1'b0, notEq:1'b0}, 4);

      // Zero wait states: ready two falling edges after the sampling edge.
      runVector(1'b1, '{name:"z_wr05", rd:1'b0, wr:1'b1, addr:16'h0045, wdata:16'h00C3,
                         expData:16'h0000, expErr:1'b0, notEq:1'b0}, 2);
      runVector(1'b1, '{name:"z_rd05", rd:1'b1, wr:1'b0, addr:16'h0045, wdata:16'h0000,
                         expData:16'h00C3, expErr:1'b0, notEq:1'b0}, 2);
      runVector(1'b1, '{name:"z_rdOor", rd:1'b1, wr:1'b0, addr:16'h0200, wdata:16'h0000,
                         expData:16'h0000, expErr:1'b1, notEq:1'b0}, 2);
      applyStimulus(1'b1, 1'b1, 1'b0, 16'h0045, 16'h0000, lat, busyFirst);
      checkOutput("z_rdAgain_latency", lat, 2);
      checkOutput("z_rdAgain_data", {16'd0, bus0.mem_data_out}, 32'h00C3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
